pipe_mux_n: RTL and testbench

PIPE_MUX_N -- requirements
Module: pipe_mux_n

---
 rtl/pipe_mux_n.sv | 129 ++++++++++++
 tb/tb_pipe_mux_n.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_n.sv
// Two-stage pipelined N:1 mux: grouped first-stage select, final select in stage 2.
// Define PIPE_MUX_N_ZERO_REG_EN to make input N-1 read as a constant zero.
module pipe_mux_n #(
  parameter int WIDTH = 64,
  parameter int N     = 32,
  parameter int GROUP = 16,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               valid_in,
  input  logic               stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   out,
  output logic               valid_out,
  output logic               oor_out
);

  localparam int GW = $clog2(GROUP);
  localparam int NG = (N + GROUP - 1) / GROUP;
  localparam int UW = (SEL_W > GW) ? SEL_W - GW : 1;
  localparam int PW = NG * GROUP * WIDTH;

  logic [WIDTH-1:0] grp_q [NG];
  logic [WIDTH-1:0] grp_d [NG];
  logic [WIDTH-1:0] grp_mux [NG];
  logic [UW-1:0]    up_q, up_d;
  logic             v1_q, v1_d;
  logic             oor1_q, oor1_d;
  logic             z1_q, z1_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             v2_q, v2_d;
  logic             oor2_q, oor2_d;

  logic [PW-1:0]    in_pad;
  logic [GW-1:0]    lo;
  logic [SEL_W-1:0] sel_hi;
  logic [31:0]      sel_ext;
  logic             oor_now;
  logic             zr_now;
  logic [WIDTH-1:0] fin_mux;

  // Missing inputs of a partial last group read as zero via the padding.
  always_comb begin
    in_pad = '0;
    in_pad[N*WIDTH-1:0] = in;
    lo      = sel[GW-1:0];
    sel_hi  = sel >> GW;
    sel_ext = 32'(sel);
    oor_now = sel_ext >= 32'(N);
`ifdef PIPE_MUX_N_ZERO_REG_EN
    zr_now  = sel_ext == 32'(N - 1);
`else
    zr_now  = 1'b0;
`endif
    for (int g = 0; g < NG; g++) begin
      grp_mux[g] = '0;
      for (int k = 0; k < GROUP; k++) begin
        if (lo == GW'(k))
          grp_mux[g] = in_pad[(g*GROUP+k)*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    fin_mux = '0;
    for (int g = 0; g < NG; g++) begin
      if (up_q == UW'(g))
        fin_mux = grp_q[g];
    end
  end

  always_comb begin
    grp_d  = grp_q;
    up_d   = up_q;
    v1_d   = v1_q;
    oor1_d = oor1_q;
    z1_d   = z1_q;
    out_d  = out_q;
    v2_d   = v2_q;
    oor2_d = oor2_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else if (!stall) begin
      v1_d = valid_in;
      if (valid_in) begin
        grp_d  = grp_mux;
        up_d   = UW'(sel_hi);
        oor1_d = oor_now;
        z1_d   = oor_now | zr_now;
      end
      v2_d = v1_q;
      if (v1_q) begin
        out_d  = z1_q ? '0 : fin_mux;
        oor2_d = oor1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grp_q  <= '{default: '0};
      up_q   <= '0;
      v1_q   <= 1'b0;
      oor1_q <= 1'b0;
      z1_q   <= 1'b0;
      out_q  <= '0;
      v2_q   <= 1'b0;
      oor2_q <= 1'b0;
    end else begin
      grp_q  <= grp_d;
      up_q   <= up_d;
      v1_q   <= v1_d;
      oor1_q <= oor1_d;
      z1_q   <= z1_d;
      out_q  <= out_d;
      v2_q   <= v2_d;
      oor2_q <= oor2_d;
    end
  end

  assign out       = out_q;
  assign valid_out = v2_q;
  assign oor_out   = oor2_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed bench for pipe_mux_n: default config plus an N=20, GROUP=8 instance.
// Expectations follow PIPE_MUX_N_ZERO_REG_EN when it is defined.
module tb_pipe_mux_n;

`ifdef PIPE_MUX_N_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_a, valid_a, stall_a, flush_a;
  logic [2047:0]   in_a;
  logic [4:0]      sel_a;
  logic [63:0]     out_a;
  logic            vo_a, oor_a;

  logic            reset_b, valid_b, stall_b, flush_b;
  logic [1279:0]   in_b;
  logic [4:0]      sel_b;
  logic [63:0]     out_b;
  logic            vo_b, oor_b;

  pipe_mux_n u_a (
    .clk(clk), .reset(reset_a), .in(in_a), .sel(sel_a),
    .valid_in(valid_a), .stall(stall_a), .flush(flush_a),
    .out(out_a), .valid_out(vo_a), .oor_out(oor_a)
  );

  pipe_mux_n #(.WIDTH(64), .N(20), .GROUP(8)) u_b (
    .clk(clk), .reset(reset_b), .in(in_b), .sel(sel_b),
    .valid_in(valid_b), .stall(stall_b), .flush(flush_b),
    .out(out_b), .valid_out(vo_b), .oor_out(oor_b)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int          bsel [7] = '{19, 23, 20, 8, 31, 0, 18};
  logic [63:0] bexp [7];
  logic        boor [7] = '{0, 1, 1, 0, 1, 0, 0};
  logic [63:0] e;

  initial begin
    bexp = '{(ZR ? 64'h0 : 64'h2013), 64'h0, 64'h0, 64'h2008,
             64'h0, 64'h2000, 64'h2012};
    reset_a = 1; valid_a = 0; stall_a = 0; flush_a = 0; sel_a = 0;
    reset_b = 1; valid_b = 0; stall_b = 0; flush_b = 0; sel_b = 0;
    for (int k = 0; k < 32; k++) in_a[k*64 +: 64] = 64'h1000 + 64'(k);
    for (int k = 0; k < 20; k++) in_b[k*64 +: 64] = 64'h2000 + 64'(k);
    step;
    step;
    chk("rst_out_a", out_a, 0);
    chk("rst_vo_a", {63'b0, vo_a}, 0);
    chk("rst_oor_a", {63'b0, oor_a}, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_vo_b", {63'b0, vo_b}, 0);
    reset_a = 0;
    reset_b = 0;

    // back-to-back sweep of every input
    for (int i = 0; i < 34; i++) begin
      sel_a = 5'(i);
      valid_a = (i < 32);
      step;
      if (i == 0 || i == 33) begin
        chk("b2b_vo_idle", {63'b0, vo_a}, 0);
      end else begin
        e = (ZR && i == 32) ? 64'h0 : 64'h1000 + 64'(i - 1);
        chk("b2b_vo", {63'b0, vo_a}, 1);
        chk("b2b_out", out_a, e);
        chk("b2b_oor", {63'b0, oor_a}, 0);
      end
    end

    // stall after capture; valid_in during stall is ignored
    sel_a = 5; valid_a = 1;
    step;
    chk("stl_vo0", {63'b0, vo_a}, 0);
    sel_a = 9; stall_a = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("stl_vo_hold", {63'b0, vo_a}, 0);
    end
    valid_a = 0; stall_a = 0;
    step;
    chk("stl_vo", {63'b0, vo_a}, 1);
    chk("stl_out", out_a, 64'h1005);
    step;
    chk("stl_vo_end", {63'b0, vo_a}, 0);
    chk("stl_out_held", out_a, 64'h1005);

    // flush together with stall kills in-flight work
    sel_a = 1; valid_a = 1;
    step;
    sel_a = 2; flush_a = 1; stall_a = 1;
    step;
    chk("fl_vo0", {63'b0, vo_a}, 0);
    chk("fl_out_data", out_a, 64'h1005);
    flush_a = 0; stall_a = 0; valid_a = 0;
    step;
    chk("fl_vo1", {63'b0, vo_a}, 0);
    sel_a = 7; valid_a = 1;
    step;
    chk("fl_vo2", {63'b0, vo_a}, 0);
    valid_a = 0;
    step;
    chk("fl_vo_new", {63'b0, vo_a}, 1);
    chk("fl_out_new", out_a, 64'h1007);

    // reset mid-flight; valid_in alongside reset is ignored
    sel_a = 3; valid_a = 1;
    step;
    sel_a = 4; reset_a = 1;
    step;
    chk("rs_vo", {63'b0, vo_a}, 0);
    chk("rs_out", out_a, 0);
    chk("rs_oor", {63'b0, oor_a}, 0);
    reset_a = 0; valid_a = 0;
    for (int i = 0; i < 2; i++) begin
      step;
      chk("rs_vo_after", {63'b0, vo_a}, 0);
      chk("rs_out_after", out_a, 0);
    end

    // last input all-ones
    in_a[31*64 +: 64] = '1;
    sel_a = 31; valid_a = 1;
    step;
    valid_a = 0;
    step;
    chk("zr_vo", {63'b0, vo_a}, 1);
    chk("zr_out", out_a, ZR ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF);
    chk("zr_oor", {63'b0, oor_a}, 0);

    // N=20 GROUP=8: partial group and out-of-range selects
    for (int i = 0; i < 8; i++) begin
      sel_b = (i < 7) ? 5'(bsel[i]) : 5'd0;
      valid_b = (i < 7);
      step;
      if (i == 0) begin
        chk("b_vo_idle", {63'b0, vo_b}, 0);
      end else begin
        chk("b_vo", {63'b0, vo_b}, 1);
        chk("b_out", out_b, bexp[i-1]);
        chk("b_oor", {63'b0, oor_b}, {63'b0, boor[i-1]});
      end
    end
    step;
    chk("b_vo_end", {63'b0, vo_b}, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
